// File: rtl/audio_mix_scheduler.sv
// rtl/audio_mix_scheduler.sv - frame scheduler mixing stereo sources into a gain-ramped DAC sample
//
// Once per SAMPLE_DIV-clock frame: clear accumulators (cnt 0), poll source i at cnt 1+i,
// saturate at cnt NSRC+1, apply the mute/unmute gain and register the DAC sample at cnt NSRC+2,
// pulse sample_stb during cnt NSRC+3.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enable               1 = ramp toward full gain, 0 = ramp toward mute
//   src_en[NSRC]         per-source mix enable
//   src_valid[NSRC]      source i presents a sample on slice i of src_l/src_r
//   src_ack[NSRC]        source i sample consumed this cycle (combinational)
//   src_l, src_r         packed signed samples, slice i = [i*DW +: DW]
//   ldatasum, rdatasum   registered signed DAC samples
//   sample_stb           one-cycle pulse when ldatasum/rdatasum carry a new value
//   ramp_level           current gain level 0..2**RAMP_BITS
//   muted                high while the ramp FSM sits in MUTED
module audio_mix_scheduler #(
    parameter int NSRC       = 3,
    parameter int DW         = 15,
    parameter int SAMPLE_DIV = 16,
    parameter int RAMP_BITS  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NSRC-1:0]        src_en,
    input  logic [NSRC-1:0]        src_valid,
    output logic [NSRC-1:0]        src_ack,
    input  logic [NSRC*DW-1:0]     src_l,
    input  logic [NSRC*DW-1:0]     src_r,
    output logic signed [DW-1:0]   ldatasum,
    output logic signed [DW-1:0]   rdatasum,
    output logic                   sample_stb,
    output logic [RAMP_BITS:0]     ramp_level,
    output logic                   muted
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int AW = DW + $clog2(NSRC) + 1;
    localparam int LW = RAMP_BITS + 1;
    localparam int PW = DW + LW + 1;

    localparam logic [CW-1:0] SLOT_CLR  = '0;
    localparam logic [CW-1:0] SLOT_SAT  = CW'(NSRC + 1);
    localparam logic [CW-1:0] SLOT_OUT  = CW'(NSRC + 2);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SAMPLE_DIV - 1);

    localparam logic [LW-1:0] LVL_MAX = LW'(1 << RAMP_BITS);

    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [1:0] ST_MUTED  = 2'd0;
    localparam logic [1:0] ST_UP     = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DOWN   = 2'd3;

    logic [CW-1:0]          cnt;
    logic signed [DW-1:0]   hold_l [NSRC];
    logic signed [DW-1:0]   hold_r [NSRC];
    logic signed [AW-1:0]   acc_l, acc_r;
    logic signed [DW-1:0]   sat_l, sat_r;
    logic signed [DW-1:0]   add_l, add_r;
    logic [1:0]             state;
    logic signed [PW-1:0]   gain;
    logic signed [PW-1:0]   prod_l, prod_r;

    function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[DW-1:0];
        else
            return a[DW-1:0];
    endfunction

    // Ack only in the source's own poll slot; cnt is 0 during reset, the reset term keeps it explicit.
    always_comb begin
        src_ack = '0;
        for (int i = 0; i < NSRC; i++)
            src_ack[i] = ~reset & (cnt == CW'(i + 1)) & src_valid[i] & src_en[i];
    end

    // Contribution of the source polled this cycle: fresh sample if acked, else its held sample.
    always_comb begin
        add_l = '0;
        add_r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cnt == CW'(i + 1)) begin
                if (src_ack[i]) begin
                    add_l = src_l[i*DW +: DW];
                    add_r = src_r[i*DW +: DW];
                end else if (src_en[i]) begin
                    add_l = hold_l[i];
                    add_r = hold_r[i];
                end
            end
        end
    end

    // Level is zero-extended so the product stays a signed multiply; at full level the
    // shift cancels exactly, giving back sat with no LSB loss.
    assign gain   = PW'({1'b0, ramp_level});
    assign prod_l = PW'(sat_l) * gain;
    assign prod_r = PW'(sat_r) * gain;

    assign muted = (state == ST_MUTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            sat_l      <= '0;
            sat_r      <= '0;
            ldatasum   <= '0;
            rdatasum   <= '0;
            sample_stb <= 1'b0;
            ramp_level <= '0;
            state      <= ST_MUTED;
            for (int i = 0; i < NSRC; i++) begin
                hold_l[i] <= '0;
                hold_r[i] <= '0;
            end
        end else begin
            cnt        <= (cnt == SLOT_LAST) ? '0 : cnt + CW'(1);
            sample_stb <= (cnt == SLOT_OUT);

            for (int i = 0; i < NSRC; i++) begin
                if (src_ack[i]) begin
                    hold_l[i] <= src_l[i*DW +: DW];
                    hold_r[i] <= src_r[i*DW +: DW];
                end
            end

            if (cnt == SLOT_CLR) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (cnt <= CW'(NSRC)) begin
                acc_l <= acc_l + AW'(add_l);
                acc_r <= acc_r + AW'(add_r);
            end

            if (cnt == SLOT_SAT) begin
                sat_l <= saturate(acc_l);
                sat_r <= saturate(acc_r);
            end

            if (cnt == SLOT_OUT) begin
                ldatasum <= DW'(prod_l >>> RAMP_BITS);
                rdatasum <= DW'(prod_r >>> RAMP_BITS);

                // Ramp advances once per frame after the current level has been applied.
                // A direction reversal costs one frame with the level unchanged.
                case (state)
                    ST_MUTED: begin
                        ramp_level <= '0;
                        if (enable)
                            state <= ST_UP;
                    end
                    ST_UP: begin
                        if (!enable) begin
                            state <= ST_DOWN;
                        end else if (ramp_level == LVL_MAX) begin
                            state <= ST_ACTIVE;
                        end else begin
                            ramp_level <= ramp_level + LW'(1);
                            if (ramp_level == LVL_MAX - LW'(1))
                                state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        ramp_level <= LVL_MAX;
                        if (!enable)
                            state <= ST_DOWN;
                    end
                    default: begin
                        if (enable) begin
                            state <= ST_UP;
                        end else if (ramp_level == '0) begin
                            state <= ST_MUTED;
                        end else begin
                            ramp_level <= ramp_level - LW'(1);
                            if (ramp_level == LW'(1))
                                state <= ST_MUTED;
                        end
                    end
                endcase
            end
        end
    end

endmodule
